// File: rtl/exec_divider.sv
// exec_divider: iterative restoring UDIV/SDIV, one quotient bit per cycle; DoneE WIDTH+2 cycles after go (1 for /0).
// Backpressure: BusyE stalls F/D/E from the go cycle through FIX; results are presented during the DoneE cycle.
module exec_divider #(
  parameter int WIDTH            = 32,
  parameter int ALUCONTROL_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        StartE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic                        FlushE,
  input  logic [WIDTH-1:0]            SrcAE,
  input  logic [WIDTH-1:0]            SrcBE,
  output logic                        BusyE,
  output logic                        DoneE,
  output logic [WIDTH-1:0]            QuotientE,
  output logic [WIDTH-1:0]            RemainderE,
  output logic                        DivZeroE
);

  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UDIV = ALUCONTROL_WIDTH'(5'b01110);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SDIV = ALUCONTROL_WIDTH'(5'b01111);
  localparam int                          CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]               LAST_IT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;

  logic             is_sdiv;
  logic             go;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_sdiv = (ALUControlE == OP_SDIV);
  assign go      = StartE & ((ALUControlE == OP_UDIV) | is_sdiv);

  // Magnitudes are unsigned, so |most-negative| = 2^(WIDTH-1) fits without overflow.
  assign a_mag = (is_sdiv & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign b_mag = (is_sdiv & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  // The quotient bits shift into the dividend register as its bits shift out.
  assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign q_fix     = qneg_q ? -dvd_q : dvd_q;
  assign r_fix     = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  assign BusyE      = ((state_q == S_IDLE) & go) | (state_q == S_RUN) | (state_q == S_FIX);
  assign DoneE      = (state_q == S_DONE);
  assign QuotientE  = quot_q;
  assign RemainderE = remo_q;
  assign DivZeroE   = divz_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    case (state_q)
      S_IDLE: begin
        if (go && !FlushE) begin
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          count_d = '0;
          qneg_d  = is_sdiv & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          rneg_d  = is_sdiv & SrcAE[WIDTH-1];
          if (SrcBE == '0) begin
            quot_d  = '0;
            remo_d  = SrcAE;
            divz_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            divz_d  = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          if (rem_shift >= {1'b0, dvs_q}) begin
            rem_d = rem_sub;
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift;
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q + CW'(1);
          if (count_q == LAST_IT) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          quot_d  = q_fix;
          remo_d  = r_fix;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
    end
  end

endmodule

// File: tb/tb_exec_divider.sv
// tb_exec_divider: directed and random UDIV/SDIV traffic for exec_divider, with flush, reset and back-to-back cases.
module tb_exec_divider;

  localparam int         W    = 32;
  localparam logic [4:0] UDIV = 5'b01110;
  localparam logic [4:0] SDIV = 5'b01111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         StartE = 1'b0;
  logic         FlushE = 1'b0;
  logic [4:0]   ALUControlE = '0;
  logic [W-1:0] SrcAE = '0;
  logic [W-1:0] SrcBE = '0;
  logic         BusyE, DoneE, DivZeroE;
  logic [W-1:0] QuotientE, RemainderE;

  exec_divider #(.WIDTH(W), .ALUCONTROL_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .ALUControlE(ALUControlE), .FlushE(FlushE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .BusyE(BusyE), .DoneE(DoneE),
    .QuotientE(QuotientE), .RemainderE(RemainderE), .DivZeroE(DivZeroE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc++;

  // Expected behaviour: busy window [m_lo, m_hi], done cycle, pending and held results.
  int           m_lo = -1, m_hi = -2, m_done = -1, m_clr = -1;
  logic [W-1:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
  logic         m_dz = 1'b0, m_pz = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '0; r = a; z = 1'b1;
    end else if (op == SDIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (cyc == m_done) begin
      m_q  = m_pq;
      m_r  = m_pr;
      m_dz = m_pz;
    end
    if (cyc == m_clr) m_dz = 1'b0;
    chk("BusyE", W'(BusyE), W'(cyc >= m_lo && cyc <= m_hi));
    chk("DoneE", W'(DoneE), W'(cyc == m_done));
    chk("QuotientE", QuotientE, m_q);
    chk("RemainderE", RemainderE, m_r);
    chk("DivZeroE", W'(DivZeroE), W'(m_dz));
  end

  task automatic do_div(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int abort_at, input bit by_reset, input bit hold,
                        output int start_c, output int done_c);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(op, a, b, eq, er, ez);
    @(posedge clk); #1;
    start_c = cyc;
    done_c  = -1;
    reset = 1'b0; StartE = 1'b1; ALUControlE = op; SrcAE = a; SrcBE = b; FlushE = 1'b0;
    lat  = ez ? 1 : W + 2;
    m_pq = eq; m_pr = er; m_pz = ez;
    m_lo = cyc;
    m_hi = ez ? cyc : cyc + W + 1;
    m_done = cyc + lat;
    m_clr  = ez ? -1 : cyc + 1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      StartE = 1'b0;
      if (by_reset) begin
        reset = 1'b1;
        m_q = '0; m_r = '0; m_dz = 1'b0;
        m_lo = -1; m_hi = -2; m_done = -1; m_clr = -1;
        @(posedge clk); #1;
        reset = 1'b0;
      end else begin
        FlushE = 1'b1;
        m_hi   = cyc;
        m_done = -1;
      end
    end else begin
      repeat (lat) @(posedge clk);
      #1;
      if (DoneE) done_c = cyc;
      if (!hold) StartE = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      StartE = 1'($urandom_range(0, 1));
      FlushE = 1'($urandom_range(0, 1));
      do ALUControlE = 5'($urandom); while (ALUControlE == UDIV || ALUControlE == SDIV);
      SrcAE = $urandom;
      SrcBE = $urandom;
    end
  endtask

  task automatic go_flush();
    @(posedge clk); #1;
    StartE = 1'b1; ALUControlE = UDIV; SrcAE = 32'd77; SrcBE = 32'd7; FlushE = 1'b1;
    m_lo = cyc; m_hi = cyc; m_done = -1;
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;
  endtask

  initial begin
    int s, d, d1, d2, ab, sel;
    bit hold;
    logic [4:0] op;
    logic [W-1:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    do_div(UDIV, 32'd100, 32'd7, 0, 0, 0, s, d);
    chk("lat_udiv", W'(d - s), 32'd34);
    chk("q_100_7", QuotientE, 32'd14);
    chk("r_100_7", RemainderE, 32'd2);
    chk("dz_100_7", W'(DivZeroE), 32'd0);
    idle(2);

    do_div(SDIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, s, d);
    chk("q_m7_2", QuotientE, 32'hFFFF_FFFD);
    chk("r_m7_2", RemainderE, 32'hFFFF_FFFF);
    do_div(SDIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, s, d);
    chk("q_7_m2", QuotientE, 32'hFFFF_FFFD);
    chk("r_7_m2", RemainderE, 32'd1);
    idle(1);

    do_div(UDIV, 32'h1234_5678, 32'd0, 0, 0, 0, s, d);
    chk("lat_div0", W'(d - s), 32'd1);
    chk("q_div0", QuotientE, 32'd0);
    chk("r_div0", RemainderE, 32'h1234_5678);
    chk("dz_div0", W'(DivZeroE), 32'd1);
    idle(1);

    do_div(SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, s, d);
    chk("q_ovf", QuotientE, 32'h8000_0000);
    chk("r_ovf", RemainderE, 32'd0);
    do_div(UDIV, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, s, d);
    chk("q_max_1", QuotientE, 32'hFFFF_FFFF);
    chk("r_max_1", RemainderE, 32'd0);

    do_div(UDIV, 32'd50, 32'd5, 11, 0, 0, s, d);
    idle(2);
    chk("q_flush_kept", QuotientE, 32'hFFFF_FFFF);
    chk("r_flush_kept", RemainderE, 32'd0);
    do_div(UDIV, 32'd9, 32'd4, 0, 0, 0, s, d);
    chk("q_9_4", QuotientE, 32'd2);
    chk("r_9_4", RemainderE, 32'd1);

    go_flush();
    idle(2);
    do_div(UDIV, 32'd1000, 32'd3, 32, 0, 0, s, d);
    idle(1);
    chk("q_lastflush_kept", QuotientE, 32'd2);

    do_div(UDIV, 32'd20, 32'd3, 0, 0, 1, s, d1);
    do_div(UDIV, 32'd1000, 32'd10, 0, 0, 0, s, d2);
    chk("b2b_gap", W'(d2 - d1), 32'd35);
    chk("q_b2b", QuotientE, 32'd100);
    idle(1);

    do_div(SDIV, 32'hFFFF_0000, 32'd3, 6, 1, 0, s, d);
    chk("q_after_reset", QuotientE, 32'd0);
    chk("r_after_reset", RemainderE, 32'd0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      op  = ($urandom_range(0, 1) == 0) ? UDIV : SDIV;
      sel = $urandom_range(0, 7);
      a   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? W'($urandom_range(0, 200)) : W'($urandom);
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
            (sel < 4) ? W'($urandom_range(1, 15)) : W'($urandom);
      ab   = (b != '0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : 0;
      hold = (ab == 0) && ($urandom_range(0, 3) == 0);
      do_div(op, a, b, ab, 0, hold, s, d);
      if (!hold) idle($urandom_range(0, 3));
    end

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
